// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall patterns, exception
// codes, FSM encoding and the redirect-target helper.
package pipe_ctrl_pkg;

    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [31:0] EXC_INT          = 32'h1;
    localparam logic [31:0] EXC_SYSCALL      = 32'h8;
    localparam logic [31:0] EXC_INST_INVALID = 32'hA;
    localparam logic [31:0] EXC_OV           = 32'hC;
    localparam logic [31:0] EXC_TRAP         = 32'hD;
    localparam logic [31:0] EXC_ERET         = 32'hE;

    typedef logic [5:0] stall_vec_t;

    localparam stall_vec_t STALL_NONE = 6'b000000;
    localparam stall_vec_t STALL_ID   = 6'b000111;
    localparam stall_vec_t STALL_EX   = 6'b001111;
    localparam stall_vec_t STALL_MEM  = 6'b011111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pc_state_t;

    function automatic logic [31:0] exc_target(input logic [31:0] code,
                                               input logic [31:0] epc,
                                               input logic [31:0] exc_vec,
                                               input logic [31:0] int_vec);
        if (code == EXC_INT)
            return int_vec;
        else if (code == EXC_ERET)
            return epc;
        else
            return exc_vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall-request / exception inputs and stall / flush outputs of the pipeline
// control unit; slave is the controller, master is the core side.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    stall_vec_t  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_count;
    logic        stall_timeout;

    modport master (
        output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_count, stall_timeout
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, stall_count, stall_timeout
    );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall activity tracking: free-running stalled-cycle count plus a sticky
// flag raised when a single stall run reaches WDOG_MAX cycles.
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter logic [15:0] WDOG_MAX = 16'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        any_stall,
    output logic [31:0] stall_count,
    output logic        stall_timeout
);

    logic [15:0] wcnt;
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wcnt          <= '0;
            cnt_q         <= '0;
            stall_timeout <= 1'b0;
        end else if (any_stall) begin
            cnt_q <= cnt_q + 32'd1;
            if (wcnt != WDOG_MAX)
                wcnt <= wcnt + 16'd1;
            // flag lands on the same edge wcnt becomes WDOG_MAX
            if ({1'b0, wcnt} + 17'd1 >= {1'b0, WDOG_MAX})
                stall_timeout <= 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests into a thermometer stall
// vector and sequences a FLUSH_CYCLES-long flush with PC redirect on exceptions.
//
// state    | meaning
// ST_RUN   | normal operation; stalls honoured, exception starts a flush
// ST_FLUSH | remaining flush cycles, counted down by fcnt_q
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [15:0] WDOG_MAX     = 16'd1023,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0020
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    localparam int unsigned FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_INIT =
        (FLUSH_CYCLES > 1) ? FCNT_W'(FLUSH_CYCLES - 2) : '0;

    pc_state_t         state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [31:0]       pc_q, pc_d;
    stall_vec_t        stall_c;
    logic              flush_c;
    logic [31:0]       new_pc_c;
    logic              any_stall;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            pc_q    <= ZeroWord;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        pc_d     = pc_q;
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = ZeroWord;
        unique case (state_q)
            ST_RUN: begin
                // an exception pre-empts any stall request in the same cycle
                if (bus.excepttype_i != ZeroWord) begin
                    flush_c  = 1'b1;
                    new_pc_c = exc_target(bus.excepttype_i, bus.cp0_epc_i,
                                          EXC_VECTOR, INT_VECTOR);
                    pc_d     = new_pc_c;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FCNT_INIT;
                    end
                end else if (bus.stallreq_from_mem) begin
                    stall_c = STALL_MEM;
                end else if (bus.stallreq_from_ex) begin
                    stall_c = STALL_EX;
                end else if (bus.stallreq_from_id) begin
                    stall_c = STALL_ID;
                end
            end
            ST_FLUSH: begin
                flush_c  = 1'b1;
                new_pc_c = pc_q;
                if (fcnt_q == '0)
                    state_d = ST_RUN;
                else
                    fcnt_d = fcnt_q - 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.stall  = (rst == RstEnable) ? STALL_NONE : stall_c;
    assign bus.flush  = (rst == RstEnable) ? 1'b0 : flush_c;
    assign bus.new_pc = (rst == RstEnable) ? ZeroWord : new_pc_c;
    assign any_stall  = (bus.stall != STALL_NONE);

    pipe_ctrl_stall_watchdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wd (
        .clk           (clk),
        .rst           (rst),
        .any_stall     (any_stall),
        .stall_count   (bus.stall_count),
        .stall_timeout (bus.stall_timeout)
    );

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the six-stage core (pc, if, id, ex, mem, wb). It merges stall requests from the id, ex and mem stages into the shared `stall[5:0]` vector that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes. On an exception or eret from the mem stage, it sequences a multi-cycle flush and supplies the redirect PC. It also tracks stall activity: a stall-cycle counter and a sticky watchdog flag for debug.

## Interface
- `FLUSH_CYCLES`, default 1: cycles `flush` stays high per exception; must be ≥1.
- `WDOG_MAX`, default 16'd1023: consecutive-stall count that sets `stall_timeout`.
- `EXC_VECTOR`, default 32'h00000040: general exception entry.
- `INT_VECTOR`, default 32'h00000020: interrupt entry.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `stallreq_from_id`  in  1  id stage needs a hold (load-use).
- `stallreq_from_ex`  in  1  ex stage multi-cycle op in progress.
- `stallreq_from_mem`  in  1  data bus not yet acknowledged.
- `excepttype_i`  in  32  mem-stage exception code; 0 means none.
- `cp0_epc_i`  in  32  current EPC, used for eret.
- `stall`  out  6  bit0 pc … bit5 wb; 1 = `Stop`.
- `flush`  out  1  clear all pipeline registers and redirect the PC.
- `new_pc`  out  32  redirect target; valid while `flush` = 1.
- `stall_count`  out  32  total stalled cycles; wraps modulo 2^32.
- `stall_timeout`  out  1  sticky watchdog flag.

## Operation
- FSM states: RUN and FLUSH. The FLUSH state uses a down-counter `fcnt`.
- **RUN, `excepttype_i` ≠ 0:**
  - `flush` = 1 and `stall` = 0 in the same cycle (combinational).
  - `new_pc` is selected as follows:
    - 32'h1 → `INT_VECTOR`
    - 32'hE (eret) → `cp0_epc_i`
    - any other nonzero code (8, A, C, D, …) → `EXC_VECTOR`
  - The selected PC is registered into `pc_q`.
  - If `FLUSH_CYCLES` > 1, go to FLUSH with `fcnt` = `FLUSH_CYCLES`−2. Otherwise stay in RUN.
- **RUN, no exception:** `flush` = 0, `new_pc` = 0. Priority is mem > ex > id:
  - mem request → `stall` = 6'b011111
  - else ex request → `stall` = 6'b001111
  - else id request → `stall` = 6'b000111
  - else `stall` = 6'b000000
- **FLUSH:**
  - `flush` = 1, `stall` = 0, `new_pc` = `pc_q`.
  - Stall requests and `excepttype_i` are ignored.
  - `fcnt` decrements each cycle. When `fcnt` = 0, return to RUN on the next edge.
- **Exception during a stall:** the exception wins. `stall` is forced to 0 that cycle and the pending stall requests are dropped.
- **`stall_count`:** increments on every cycle where `stall` ≠ 0; wraps from 32'hFFFFFFFF to 0.
- **Watchdog:**
  - 16-bit `wcnt` increments each cycle `stall` ≠ 0, saturates at `WDOG_MAX`, and clears on any cycle with `stall` = 0.
  - `stall_timeout` sets on the edge where `wcnt` reaches `WDOG_MAX` and stays set until reset.

## Timing
- **Reset:** state = RUN, `fcnt` = 0, `pc_q` = 0, `stall_count` = 0, `wcnt` = 0, `stall_timeout` = 0. While `rst` = 1, all outputs are driven 0 regardless of inputs (`stall` = 0, `flush` = 0, `new_pc` = 0).
- **Reset mid-flush:** abandons FLUSH; RUN resumes on the cycle after `rst` falls.
- `stall` and the first cycle of `flush` are combinational from the inputs (zero latency). Downstream registers sample them on the same edge.
- Remaining flush cycles and all counters are registered (one-edge latency).
- Total `flush` duration is exactly `FLUSH_CYCLES` consecutive cycles per exception.
- `stall` bits are always contiguous from bit0 (a thermometer code). A stage may never advance while an earlier stage holds.

## Structure
- Shared defines package (defines.v) holds: `Stop`/`NoStop`, `RstEnable`, `ZeroWord`, exception code constants (EXC_INT = 32'h1, EXC_SYSCALL = 32'h8, EXC_INST_INVALID = 32'hA, EXC_OV = 32'hC, EXC_TRAP = 32'hD, EXC_ERET = 32'hE), the stall pattern constants, and the FSM state encodings.
- One natural sub-module, `stall_watchdog`: contains `wcnt`, `stall_timeout` and `stall_count`, driven by the signal `any_stall`.

## Test plan
- Reset with all requests high → `stall` = 0, `flush` = 0, counters 0. After release with only `stallreq_from_ex` = 1 → `stall` = 6'b001111 and `stall_count` increments each cycle.
- `stallreq_from_id`, `stallreq_from_ex` and `stallreq_from_mem` all 1 → 6'b011111. Drop mem → 6'b001111. Drop ex → 6'b000111.
- `FLUSH_CYCLES` = 3, `excepttype_i` = 32'hC for one cycle while `stallreq_from_mem` = 1 → `flush` high for exactly 3 cycles, `new_pc` = 32'h40 throughout, `stall` = 0 throughout.
- `excepttype_i` = 32'hE with `cp0_epc_i` = 32'h00001234 → `new_pc` = 32'h00001234. With `excepttype_i` = 32'h1 → `new_pc` = 32'h20.
- `WDOG_MAX` = 5, `stallreq_from_id` held 5 cycles → `stall_timeout` rises after the 5th stalled cycle and stays 1 after the request drops. A 4-cycle stall, a 1-cycle gap, then a 4-cycle stall → flag stays 0.
- Preload `stall_count` to 32'hFFFFFFFF via a long stall (or a force in the bench), then one more stalled cycle → `stall_count` = 0. Assert `rst` mid-flush → `flush` = 0 the next cycle.
